// File: rtl/gate_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_sweep_pkg
// Description : Shared types and truth-table constants for the gate sweep.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VEC = 4;

  // Bit idx holds the expected F for AB = {idx[0], idx[1]}
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

endpackage
`default_nettype wire

// File: rtl/gate_sweep_ctrl_hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : hold_timer
// Description : Loadable down-counter with a zero flag; stops at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module hold_timer #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/gate_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gate_sweep_ctrl
// Description : Drives all four AB vectors into a 2-input gate, samples F
//               after a settle time and reports mismatches against a table.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int         HOLD_CYCLES = 5,
  parameter logic [3:0] EXP_TABLE   = 4'b1000,
  parameter int         CNT_W       = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             F_i,
  output logic             A_o,
  output logic             B_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [3:0]       err_mask_o,
  output logic [1:0]       vec_idx_o
);

  localparam int            TW     = $clog2(HOLD_CYCLES) + 1;
  localparam logic [TW-1:0] c_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [1:0]    c_LAST = 2'(NUM_VEC - 1);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_idx, w_idx_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_pass, w_pass_nxt;
  logic [CNT_W-1:0] r_err_cnt, w_cnt_nxt, w_cnt_upd;
  logic [3:0]       r_err_mask, w_mask_nxt, w_mask_upd;
  logic             w_load, w_dec, w_zero, w_miss;

  hold_timer #(.W(TW)) u_hold_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_load     (w_load),
    .i_load_val (c_LOAD),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  assign w_miss     = (F_i != EXP_TABLE[r_idx]);
  assign w_mask_upd = r_err_mask | (4'(w_miss) << r_idx);
  assign w_cnt_upd  = r_err_cnt + CNT_W'(w_miss);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_pass_nxt  = r_pass;
    w_cnt_nxt   = r_err_cnt;
    w_mask_nxt  = r_err_mask;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i && !abort_i) begin
          w_state_nxt = SETTLE;
          w_idx_nxt   = 2'd0;
          w_busy_nxt  = 1'b1;
          w_pass_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_mask_nxt  = '0;
          w_load      = 1'b1;
        end
      end
      SETTLE: begin
        if (abort_i) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = 2'd0;
          w_busy_nxt  = 1'b0;
          w_pass_nxt  = 1'b0;
        end else if (w_zero) begin
          w_state_nxt = SAMPLE;
        end else begin
          w_dec = 1'b1;
        end
      end
      SAMPLE: begin
        // An abort here discards the sample taken in this cycle
        if (abort_i) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = 2'd0;
          w_busy_nxt  = 1'b0;
          w_pass_nxt  = 1'b0;
        end else begin
          w_cnt_nxt  = w_cnt_upd;
          w_mask_nxt = w_mask_upd;
          if (r_idx == c_LAST) begin
            w_state_nxt = DONE;
            w_idx_nxt   = 2'd0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = (w_mask_upd == 4'd0);
          end else begin
            w_state_nxt = SETTLE;
            w_idx_nxt   = r_idx + 2'd1;
            w_load      = 1'b1;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_idx      <= 2'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err_cnt  <= '0;
      r_err_mask <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_pass     <= w_pass_nxt;
      r_err_cnt  <= w_cnt_nxt;
      r_err_mask <= w_mask_nxt;
    end
  end

  assign A_o        = r_idx[0];
  assign B_o        = r_idx[1];
  assign vec_idx_o  = r_idx;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign pass_o     = r_pass;
  assign err_cnt_o  = r_err_cnt;
  assign err_mask_o = r_err_mask;

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_sweep_ctrl
// Description : Randomised scoreboard bench for gate_sweep_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_sweep_ctrl;

  localparam int         H     = 5;
  localparam int         P     = H + 1;
  localparam logic [3:0] c_EXP = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic [3:0] gate_tt = 4'b1000;
  logic       F_i;
  logic       A_o, B_o, busy_o, done_o, pass_o;
  logic [2:0] err_cnt_o;
  logic [3:0] err_mask_o;
  logic [1:0] vec_idx_o;

  // Emulated gate: output looked up from its truth table at index {B,A}
  assign F_i = gate_tt[{B_o, A_o}];

  gate_sweep_ctrl #(.HOLD_CYCLES(H), .EXP_TABLE(c_EXP), .CNT_W(3)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .F_i        (F_i),
    .A_o        (A_o),
    .B_o        (B_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .pass_o     (pass_o),
    .err_cnt_o  (err_cnt_o),
    .err_mask_o (err_mask_o),
    .vec_idx_o  (vec_idx_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mask;
    logic       pass;
    int         start;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         edge_no = 0;
  bit         m_active = 0;
  bit         m_done = 0;
  bit         m_pass = 0;
  logic [3:0] m_mask = 4'd0;
  logic [3:0] m_full = 4'd0;
  int         m_start = 0;
  int         mon_idx;
  exp_t       mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mismatches become visible once their vector's sample edge has passed
  function automatic logic [3:0] partial(input logic [3:0] full, input int k);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 4; i++)
      if (P * (i + 1) <= k) r[i] = full[i];
    return r;
  endfunction

  task automatic model_reset();
    m_active = 0;
    m_done   = 0;
    m_pass   = 0;
    m_mask   = 4'd0;
    sb.delete();
  endtask

  task automatic tick();
    logic s, a;
    bit   prev_done;
    int   k;
    s = start_i;
    a = abort_i;
    prev_done = m_done;
    @(posedge clk);
    #1;
    edge_no++;
    m_done = 0;
    if (rst_i) begin
      model_reset();
    end else if (m_active) begin
      k = edge_no - m_start;
      if (a) begin
        m_active = 0;
        m_pass   = 0;
        if (sb.size() > 0) sb.delete(sb.size() - 1);
      end else if (k == 4 * P) begin
        m_active = 0;
        m_done   = 1;
        m_mask   = m_full;
        m_pass   = (m_full == 4'd0);
      end else begin
        m_mask = partial(m_full, k);
      end
    end else if (s && !a && !prev_done) begin
      m_active = 1;
      m_start  = edge_no;
      m_full   = gate_tt ^ c_EXP;
      m_mask   = 4'd0;
      m_pass   = 0;
      sb.push_back('{m_full, (m_full == 4'd0), edge_no});
    end
  endtask

  task automatic run_sweep(input logic [3:0] tt);
    gate_tt = tt;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (4 * P + 2) tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_A"}, A_o, 0);
    chk({tag, "_B"}, B_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_pass"}, pass_o, 0);
    chk({tag, "_cnt"}, err_cnt_o, 0);
    chk({tag, "_mask"}, err_mask_o, 0);
    chk({tag, "_idx"}, vec_idx_o, 0);
  endtask

  always @(negedge clk) begin
    if (!rst_i) begin
      mon_idx = m_active ? (edge_no - m_start) / P : 0;
      chk("busy", busy_o, m_active);
      chk("A", A_o, mon_idx[0]);
      chk("B", B_o, mon_idx[1]);
      chk("vec_idx", vec_idx_o, mon_idx[1:0]);
      chk("done", done_o, m_done);
      chk("pass", pass_o, m_pass);
      chk("err_cnt", err_cnt_o, $countones(m_mask));
      chk("err_mask", err_mask_o, m_mask);
      if (done_o) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected actual=1 expected=0 (t=%0t)", $time);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_mask", err_mask_o, mon_e.mask);
          chk("sb_cnt", err_cnt_o, $countones(mon_e.mask));
          chk("sb_pass", pass_o, mon_e.pass);
          chk("sb_latency", edge_no - mon_e.start, 4 * P);
        end
      end
    end
  end

  initial begin
    #2 rst_i = 1'b1;
    #1 chk_all_zero("rst");
    repeat (2) tick();
    rst_i = 1'b0;
    tick();

    run_sweep(4'b1000);  // good AND
    run_sweep(4'b0000);  // stuck at 0
    run_sweep(4'b0111);  // NAND

    // Abort in vector 1 settle, then a clean sweep
    gate_tt = 4'b1000;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (9) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    repeat (3) tick();
    run_sweep(4'b1000);

    // Start re-pulses during the sweep and in DONE are ignored
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (2) tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (20) tick();
    start_i = 1'b1;
    repeat (2) tick();
    start_i = 1'b0;
    repeat (3) tick();

    // Start with coincident abort in IDLE does nothing
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    repeat (3) tick();

    for (int it = 0; it < 30; it++) begin
      while (m_active || m_done) tick();
      gate_tt = 4'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int c = 0; c < 4 * P + 3; c++) begin
        start_i = ($urandom_range(0, 9) == 0);
        abort_i = ($urandom_range(0, 39) == 0);
        tick();
      end
      start_i = 1'b0;
      abort_i = 1'b0;
      tick();
    end
    while (m_active || m_done) tick();

    // Asynchronous reset in the middle of a sweep
    gate_tt = 4'b0000;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (8) tick();
    chk("pre_rst_busy", busy_o, 1);
    #2 rst_i = 1'b1;
    #1 chk_all_zero("async_rst");
    model_reset();
    repeat (2) tick();
    rst_i = 1'b0;
    tick();
    run_sweep(4'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
Sequencer that exhaustively exercises a 2-input combinational gate (and_gate style: inputs A/B, output F) in-system. On start it drives the four input vectors in order, holds each for a programmable settle time, samples the gate output and compares it against a parameterised truth table. It then reports the mismatch count, a per-vector fail mask and a pass flag. It sits between a host/start source and the gate under check.

Parameters:
HOLD_CYCLES, 5, settle cycles per vector before sampling F_i; legal range >= 1
EXP_TABLE, 4'b1000, expected F per vector index idx (bit idx); default = AND
CNT_W, 3, width of err_cnt_o; must be >= 3 so that 4 errors fit

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
start_i  input  1  begin sweep; accepted only in IDLE
abort_i  input  1  cancel sweep in progress
F_i  input  1  gate output under check
A_o  output  1  gate input A
B_o  output  1  gate input B
busy_o  output  1  high while a sweep is in progress
done_o  output  1  one-cycle pulse at sweep completion
pass_o  output  1  1 = last completed sweep had zero mismatches; held until next start
err_cnt_o  output  CNT_W  mismatch count of current/last sweep
err_mask_o  output  4  bit idx set = vector idx mismatched
vec_idx_o  output  2  index of vector currently driven

Behaviour:
- Reset (async, any time incl. mid-sweep): state=IDLE; A_o=B_o=0, busy_o=0, done_o=0, pass_o=0, err_cnt_o=0, err_mask_o=0, vec_idx_o=0, hold counter=0.
- Vector order: idx 0..3; A_o=idx[0], B_o=idx[1], i.e. AB = 00,10,01,11. Expected value = EXP_TABLE[idx].
- All outputs are registered; F_i is sampled synchronously.
- FSM states:
  IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  start_i=1 and abort_i=0 -> clear err_cnt/err_mask, pass_o=0, idx=0, AB=00, counter=HOLD_CYCLES-1, go to SETTLE.
- SETTLE:
  busy_o=1; counter decrements each cycle. Counter==0 -> SAMPLE. Occupies exactly HOLD_CYCLES cycles.
- SAMPLE:
  One cycle. If F_i != EXP_TABLE[idx]: err_cnt+1 and err_mask[idx]=1.
  idx<3 -> idx+1, drive next AB, reload counter, go to SETTLE.
  idx==3 -> DONE.
- DONE:
  One cycle. done_o=1, busy_o=0, pass_o=(err_mask==0) including the final sample, A_o=B_o=0, idx=0. Next state IDLE.
- Timing:
  Each vector occupies HOLD_CYCLES+1 cycles. If start_i is sampled at edge E0, done_o is high in the cycle after edge E0+4*(HOLD_CYCLES+1); with the default this is edge 24.
- start_i outside IDLE (SETTLE, SAMPLE, DONE) is ignored. There is no queuing.
- abort_i in SETTLE or SAMPLE:
  - Next edge -> IDLE with A_o=B_o=0, busy_o=0, pass_o=0.
  - No done_o pulse.
  - err_cnt_o/err_mask_o keep their partial values.
  - abort_i takes priority over a coincident SAMPLE update; that sample is discarded.
- abort_i in IDLE or DONE has no effect. start_i and abort_i together in IDLE -> stay IDLE.
- err_cnt_o cannot exceed 4, so no saturation logic is required.

Decomposition:
- Package gate_sweep_pkg:
  - state enum {IDLE, SETTLE, SAMPLE, DONE}
  - NUM_VEC=4
  - truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111
- One sub-module, hold_timer: loadable down-counter with a zero flag, width $clog2(HOLD_CYCLES)+1.

Test Plan:
- Reset: assert rst_i mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
- Good AND (F_i=A_o&B_o), start pulse at edge 0:
  - AB = 00,10,01,11, each held 6 cycles; vec_idx_o follows the same sequence.
  - done_o pulses once after edge 24; pass_o=1, err_cnt_o=0, err_mask_o=4'b0000; busy_o low from that cycle on.
- F_i stuck at 0 -> err_cnt_o=1, err_mask_o=4'b1000, pass_o=0.
- NAND gate (F_i=~(A_o&B_o)) with EXP_TABLE=TT_AND -> err_cnt_o=4, err_mask_o=4'b1111, pass_o=0.
- abort_i at edge 10 (vector 1, SETTLE):
  - From edge 11: busy_o=0, AB=00, no done_o.
  - A subsequent start runs a full 24-cycle sweep and passes.
- start_i re-pulsed at edges 3 and 24 during a sweep -> ignored; exactly one done_o pulse, and busy_o does not retrigger.
